usb_tx_ctrl: RTL and testbench

Transmit scheduler placed in front of `usb_tx` in the USB bulk endpoint. Accepts ACK/NAK handshake requests from the protocol controller and DATA send requests from the AHB-side buffer logic, arbitrates between them, and issues one packet at a time on `usb_tx`'s `tx_packet`/`tx_packet_size` command port. Packet completion is detected from the line-side EOP, and an inter-packet gap is enforced before the next launch. Data bytes are relayed from the FIFO into `usb_tx` on each `get_tx_packet_data` request, with a per-packet byte count.

---
 rtl/usb_pkg.sv | 24 ++
 rtl/usb_eop_detect.sv | 48 ++++
 rtl/usb_tx_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_usb_tx_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB bulk-endpoint transmit path.
//   tx_cmd_t     - command encoding presented to usb_tx on tx_packet
//   ctrl_state_t - state of the transmit scheduler in usb_tx_ctrl
//   MAX_PKT_BYTES - largest legal bulk DATA payload
package usb_pkg;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'b00,
      TX_SEND_DATA = 2'b01,
      TX_NAK       = 2'b10,
      TX_ACK       = 2'b11
   } tx_cmd_t;

   localparam int unsigned MAX_PKT_BYTES = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_SE0,
      ST_WAIT_J,
      ST_GAP
   } ctrl_state_t;

endpackage

// File: rtl/usb_eop_detect.sv
// usb_eop_detect: watches the usb_tx line outputs for an end-of-packet.
// Ports:
//   clk, rst    - system clock, asynchronous active-high reset
//   dplus_out   - D+ driven by usb_tx
//   dminus_out  - D- driven by usb_tx
//   arm         - detection enabled; while low all history is discarded
//   se0_seen    - two consecutive SE0 cycles observed since arming (level)
//   eop_seen    - se0_seen and the line is now at J (combinational)
module usb_eop_detect (
   input  logic clk,
   input  logic rst,
   input  logic dplus_out,
   input  logic dminus_out,
   input  logic arm,
   output logic se0_seen,
   output logic eop_seen
);

   logic se0;
   logic j_state;
   logic se0_prev;
   logic seen_q;

   assign se0     = ~dplus_out & ~dminus_out;
   assign j_state =  dplus_out & ~dminus_out;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         se0_prev <= 1'b0;
         seen_q   <= 1'b0;
      end else if (!arm) begin
         se0_prev <= 1'b0;
         seen_q   <= 1'b0;
      end else begin
         se0_prev <= se0;
         // Sticky once two back-to-back SE0 samples are seen; the J that
         // follows may come several cycles later.
         if (se0 && se0_prev)
            seen_q <= 1'b1;
      end
   end

   assign se0_seen = seen_q;
   assign eop_seen = seen_q & j_state;

endmodule

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: transmit scheduler in front of usb_tx.
// Arbitrates ACK/NAK/DATA requests (NAK > ACK > DATA), holds the command on
// tx_packet for HOLD_CYCLES, waits for the line EOP, enforces an inter-packet
// gap, and relays FIFO bytes to usb_tx with a per-packet byte count.
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   send_ack/nak/data   - one-cycle requests; data_size sampled with send_data
//   data_size           - DATA payload length (0..64 legal)
//   fifo_rdata/fifo_pop - TX FIFO head byte / one-cycle pop
//   get_tx_packet_data  - byte request from usb_tx (rising edge significant)
//   dplus_out/dminus_out- usb_tx line outputs, monitored for EOP
//   tx_packet/_size/_data - command, payload size and byte to usb_tx
//   tx_busy             - packet in flight or in the gap
//   tx_done/tx_error    - one-cycle completion / error pulses
module usb_tx_ctrl
   import usb_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES    = 9,
   parameter int unsigned IPG_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 8192
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_ack,
   input  logic       send_nak,
   input  logic       send_data,
   input  logic [6:0] data_size,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_pop,
   input  logic       get_tx_packet_data,
   input  logic       dplus_out,
   input  logic       dminus_out,
   output logic [1:0] tx_packet,
   output logic [6:0] tx_packet_size,
   output logic [7:0] tx_packet_data,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int unsigned PH_MAX = (HOLD_CYCLES > IPG_CYCLES) ? HOLD_CYCLES : IPG_CYCLES;
   localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

   ctrl_state_t       state, state_n;
   tx_cmd_t           cmd_q, cmd_n;
   logic              p_ack, p_nak, p_data;
   logic [6:0]        size_q;       // size held with the pending DATA request
   logic [6:0]        pkt_size;     // size of the packet currently launched
   logic [6:0]        byte_cnt;
   logic [PH_W-1:0]   ph_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              get_q;
   logic              overrun_q;

   logic data_ok, size_err;
   logic eff_ack, eff_nak, eff_data;
   logic [6:0] eff_size;
   logic launch, done_evt, timeout, in_flight;
   logic hold_end, gap_end;
   logic get_rise, byte_avail, relay_pop, relay_over;
   logic se0_seen, eop_seen, arm;

   // Oversize DATA requests are rejected outright and never become pending.
   assign data_ok  = send_data && (data_size <= 7'(MAX_PKT_BYTES));
   assign size_err = send_data && (data_size >  7'(MAX_PKT_BYTES));

   // Requests arriving this cycle count as pending so an idle launch costs
   // only one cycle of latency.
   assign eff_nak  = p_nak  | send_nak;
   assign eff_ack  = p_ack  | send_ack;
   assign eff_data = p_data | data_ok;
   assign eff_size = p_data ? size_q : data_size;

   assign in_flight = (state == ST_LAUNCH) || (state == ST_WAIT_SE0) || (state == ST_WAIT_J);
   assign arm       = (state == ST_WAIT_SE0) || (state == ST_WAIT_J);
   assign timeout   = in_flight && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign hold_end  = (ph_cnt == PH_W'(HOLD_CYCLES - 1));
   assign gap_end   = (ph_cnt == PH_W'(IPG_CYCLES - 1));

   usb_eop_detect u_eop (
      .clk        (clk),
      .rst        (rst),
      .dplus_out  (dplus_out),
      .dminus_out (dminus_out),
      .arm        (arm),
      .se0_seen   (se0_seen),
      .eop_seen   (eop_seen)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave it unassigned and infer a latch.
   always_comb begin
      state_n  = state;
      cmd_n    = TX_IDLE;
      launch   = 1'b0;
      done_evt = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (eff_nak) begin
               launch = 1'b1;
               cmd_n  = TX_NAK;
            end else if (eff_ack) begin
               launch = 1'b1;
               cmd_n  = TX_ACK;
            end else if (eff_data) begin
               launch = 1'b1;
               cmd_n  = TX_SEND_DATA;
            end
            if (launch) state_n = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            if (timeout)       state_n = ST_GAP;
            else if (hold_end) state_n = ST_WAIT_SE0;
         end
         ST_WAIT_SE0: begin
            if (timeout)       state_n = ST_GAP;
            else if (se0_seen) state_n = ST_WAIT_J;
         end
         ST_WAIT_J: begin
            if (timeout) begin
               state_n = ST_GAP;
            end else if (eop_seen) begin
               done_evt = 1'b1;
               state_n  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_end) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Pending flags, launched packet attributes and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_ack    <= 1'b0;
         p_nak    <= 1'b0;
         p_data   <= 1'b0;
         size_q   <= '0;
         cmd_q    <= TX_IDLE;
         pkt_size <= '0;
         ph_cnt   <= '0;
         tmo_cnt  <= '0;
      end else begin
         // A launched NAK also retires a pending ACK.
         p_nak  <= eff_nak  & ~(launch && cmd_n == TX_NAK);
         p_ack  <= eff_ack  & ~(launch && (cmd_n == TX_NAK || cmd_n == TX_ACK));
         p_data <= eff_data & ~(launch && cmd_n == TX_SEND_DATA);
         if (data_ok && !p_data)
            size_q <= data_size;

         if (launch) begin
            cmd_q    <= cmd_n;
            pkt_size <= (cmd_n == TX_SEND_DATA) ? eff_size : 7'd0;
         end

         ph_cnt <= (state_n != state) ? '0 : ph_cnt + PH_W'(1);

         if (launch)         tmo_cnt <= '0;
         else if (in_flight) tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // Byte relay: only rising edges of the request count, and only while a
   // packet is in flight.
   assign get_rise   = get_tx_packet_data & ~get_q;
   assign byte_avail = (byte_cnt < pkt_size);
   assign relay_pop  = in_flight && get_rise && byte_avail;
   assign relay_over = in_flight && get_rise && !byte_avail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         get_q     <= 1'b0;
         byte_cnt  <= '0;
         overrun_q <= 1'b0;
         fifo_pop  <= 1'b0;
         tx_done   <= 1'b0;
         tx_error  <= 1'b0;
      end else begin
         get_q    <= get_tx_packet_data;
         fifo_pop <= relay_pop;

         if (launch)         byte_cnt <= '0;
         else if (relay_pop) byte_cnt <= byte_cnt + 7'd1;

         if (launch)          overrun_q <= 1'b0;
         else if (relay_over) overrun_q <= 1'b1;

         tx_done  <= done_evt;
         tx_error <= size_err | timeout | (done_evt & overrun_q);
      end
   end

   assign tx_packet      = (state == ST_LAUNCH) ? cmd_q    : TX_IDLE;
   assign tx_packet_size = (state == ST_LAUNCH) ? pkt_size : 7'd0;
   // Once the payload is exhausted usb_tx is fed zeros instead of FIFO data.
   assign tx_packet_data = (in_flight && !byte_avail) ? 8'h00 : fifo_rdata;
   assign tx_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb_usb_tx_ctrl: directed self-checking bench for usb_tx_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_usb_tx_ctrl;
   import usb_pkg::*;

   localparam int HOLD = 9;
   localparam int IPG  = 16;
   localparam int TMO  = 8192;

   logic       clk = 1'b0;
   logic       rst;
   logic       send_ack, send_nak, send_data;
   logic [6:0] data_size;
   logic [7:0] fifo_rdata;
   logic       fifo_pop;
   logic       get_tx_packet_data;
   logic       dplus_out, dminus_out;
   logic [1:0] tx_packet;
   logic [6:0] tx_packet_size;
   logic [7:0] tx_packet_data;
   logic       tx_busy, tx_done, tx_error;

   int n_total = 0;
   int n_bad   = 0;

   // FIFO model and event monitors
   logic [7:0] fifo_mem [0:3];
   int fifo_idx = 0;
   int pop_cnt  = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   always #5 clk = ~clk;

   assign fifo_rdata = fifo_mem[fifo_idx];

   always @(posedge clk) begin
      if (fifo_pop) begin
         pop_cnt <= pop_cnt + 1;
         if (fifo_idx < 3) fifo_idx <= fifo_idx + 1;
      end
      if (tx_done)  done_cnt <= done_cnt + 1;
      if (tx_error) err_cnt  <= err_cnt + 1;
   end

   usb_tx_ctrl #(
      .HOLD_CYCLES    (HOLD),
      .IPG_CYCLES     (IPG),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .send_ack           (send_ack),
      .send_nak           (send_nak),
      .send_data          (send_data),
      .data_size          (data_size),
      .fifo_rdata         (fifo_rdata),
      .fifo_pop           (fifo_pop),
      .get_tx_packet_data (get_tx_packet_data),
      .dplus_out          (dplus_out),
      .dminus_out         (dminus_out),
      .tx_packet          (tx_packet),
      .tx_packet_size     (tx_packet_size),
      .tx_packet_data     (tx_packet_data),
      .tx_busy            (tx_busy),
      .tx_done            (tx_done),
      .tx_error           (tx_error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Called on the first launch cycle; returns on the first cycle after hold.
   task automatic measure_hold(input string tag, input tx_cmd_t cmd, input logic [6:0] size);
      int n = 0;
      check({tag, "_cmd"},  tx_packet, cmd);
      check({tag, "_size"}, tx_packet_size, size);
      check({tag, "_busy"}, tx_busy, 1);
      while (tx_packet != TX_IDLE && n < 30) begin
         n++;
         tick();
      end
      check({tag, "_hold"}, n, HOLD);
   endtask

   // Line model: SE0, SE0, then J; then checks done/error and the gap length.
   task automatic finish_pkt(input string tag, input logic exp_err);
      int n = 0;
      dplus_out = 1'b0; dminus_out = 1'b0;
      tick(); tick();
      dplus_out = 1'b1;
      while (!tx_done && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_done"}, tx_done, 1);
      check({tag, "_err_at_done"}, tx_error, exp_err);
      n = 0;
      while (tx_busy && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_gap"}, n, IPG);
   endtask

   initial begin
      int n, launches, d0, e0, p0;
      fifo_mem = '{8'hF0, 8'h0F, 8'h55, 8'h55};
      rst = 1'b1;
      send_ack = 1'b0; send_nak = 1'b0; send_data = 1'b0; data_size = '0;
      get_tx_packet_data = 1'b0;
      dplus_out = 1'b1; dminus_out = 1'b0;

      // Reset values
      tick(); tick();
      check("rst_packet", tx_packet, TX_IDLE);
      check("rst_size",   tx_packet_size, 0);
      check("rst_data",   tx_packet_data, 8'hF0);
      check("rst_pop",    fifo_pop, 0);
      check("rst_busy",   tx_busy, 0);
      check("rst_done",   tx_done, 0);
      check("rst_error",  tx_error, 0);
      rst = 1'b0;
      tick();

      // NAK: one-cycle latency, 9-cycle hold, EOP, 16-cycle gap
      send_nak = 1'b1;
      check("nak_latency", tx_packet, TX_IDLE);
      tick();
      send_nak = 1'b0;
      measure_hold("nak", TX_NAK, 0);
      finish_pkt("nak", 1'b0);

      // NAK and ACK together: NAK wins, ACK is dropped
      send_nak = 1'b1; send_ack = 1'b1;
      tick();
      send_nak = 1'b0; send_ack = 1'b0;
      measure_hold("nakack", TX_NAK, 0);
      finish_pkt("nakack", 1'b0);
      launches = 0;
      repeat (5) begin
         tick();
         if (tx_packet != TX_IDLE) launches++;
      end
      check("ack_dropped", launches, 0);

      // ACK and DATA(2) together: ACK first, DATA after the gap
      send_ack = 1'b1; send_data = 1'b1; data_size = 7'd2;
      tick();
      send_ack = 1'b0; send_data = 1'b0; data_size = 7'd0;
      measure_hold("ack", TX_ACK, 0);
      finish_pkt("ack", 1'b0);
      tick();
      measure_hold("data2", TX_SEND_DATA, 7'd2);

      // Byte relay with one overrun request
      get_tx_packet_data = 1'b1; #1;
      check("byte0_data", tx_packet_data, 8'hF0);
      tick();
      check("byte0_pop", fifo_pop, 1);
      get_tx_packet_data = 1'b0;
      tick();
      get_tx_packet_data = 1'b1; #1;
      check("byte1_data", tx_packet_data, 8'h0F);
      tick();
      check("byte1_pop", fifo_pop, 1);
      get_tx_packet_data = 1'b0;
      tick();
      get_tx_packet_data = 1'b1; #1;
      check("byte2_data", tx_packet_data, 8'h00);
      tick();
      check("byte2_nopop", fifo_pop, 0);
      get_tx_packet_data = 1'b0;
      tick();
      check("pop_count", pop_cnt, 2);
      finish_pkt("data2", 1'b1);

      // Oversize DATA request
      send_data = 1'b1; data_size = 7'd70;
      tick();
      send_data = 1'b0; data_size = 7'd0;
      check("big_error", tx_error, 1);
      check("big_busy",  tx_busy, 0);
      tick();
      check("big_error_pulse", tx_error, 0);
      check("big_no_launch", tx_packet, TX_IDLE);

      // Timeout: no SE0 ever appears on the line
      send_ack = 1'b1;
      tick();
      send_ack = 1'b0;
      check("tmo_launch", tx_packet, TX_ACK);
      d0 = done_cnt;
      n = 0;
      while (!tx_error && n < 9000) begin
         tick();
         n++;
      end
      check("tmo_cycles", n, TMO);
      n = 0;
      while (tx_busy && n < 40) begin
         tick();
         n++;
      end
      check("tmo_gap", n, IPG);
      check("tmo_no_done", done_cnt, d0);

      // Zero-length DATA, then reset in WAIT_SE0 with a NAK pending
      p0 = pop_cnt;
      send_data = 1'b1; data_size = 7'd0;
      tick();
      send_data = 1'b0;
      measure_hold("zlp", TX_SEND_DATA, 0);
      send_nak = 1'b1;
      tick();
      send_nak = 1'b0;
      check("zlp_wait_busy", tx_busy, 1);
      d0 = done_cnt; e0 = err_cnt;
      rst = 1'b1; #1;
      check("midrst_busy", tx_busy, 0);
      tick();
      rst = 1'b0;
      launches = 0;
      repeat (40) begin
         tick();
         if (tx_packet != TX_IDLE) launches++;
      end
      check("midrst_no_launch", launches, 0);
      check("midrst_no_done", done_cnt, d0);
      check("midrst_no_error", err_cnt, e0);
      check("zlp_no_pop", pop_cnt, p0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
